mem_access_unit: RTL and testbench

- Initiator side of the data-memory port in the 32-bit pipeline MEM stage.
- Accepts byte-addressed load/store requests from EX over a valid/ready handshake.
- Drives the 256x32 synchronous data memory (8-bit word address, 1-cycle registered read, write-done pulse).
- Performs sub-word formatting, sign/zero extension and read-modify-write for byte/halfword stores, then returns one response per request to WB.

---
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the 256x32 synchronous data memory: accepts byte-addressed
// loads/stores, formats sub-word data (RMW for byte/half stores) and returns one response each.
module mem_access_unit #(
  parameter int WD_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_store,
  output logic        resp_err,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_wd,
  output logic [2:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the request side latches all req_* fields then, the response side holds resp_* until then.

  localparam int CW = $clog2(WD_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD, DATA, WR, WAIT_WD, RESP} state_t;

  state_t       state;
  logic         we_q;
  logic [1:0]   size_q;
  logic         uns_q;
  logic [1:0]   lo_q;
  logic [15:0]  wdata_q;
  logic [CW-1:0] wd_cnt;

  logic         acc_err;
  logic [7:0]   byte_sel;
  logic [15:0]  half_sel;
  logic [31:0]  load_data;
  logic [31:0]  merged;

  assign dbg_state = state;

  always_comb begin
    acc_err = (req_size == 2'b11) ||
              (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
              (req_addr[31:10] != 22'd0);
  end

  // Lane extraction and sign/zero extension for loads.
  always_comb begin
    byte_sel  = mem_rdata[{lo_q, 3'b000} +: 8];
    half_sel  = mem_rdata[{lo_q[1], 4'b0000} +: 16];
    load_data = mem_rdata;
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  // Read-modify-write: only the addressed lane takes the new store data.
  always_comb begin
    merged = mem_rdata;
    if (size_q == 2'b00) merged[{lo_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 merged[{lo_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_rd    <= 5'd0;
      resp_store <= 1'b0;
      resp_err   <= 1'b0;
      mem_addr   <= 8'd0;
      mem_wdata  <= 32'd0;
      mem_we     <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      lo_q       <= 2'b00;
      wdata_q    <= 16'd0;
      wd_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            size_q     <= req_size;
            uns_q      <= req_unsigned;
            lo_q       <= req_addr[1:0];
            wdata_q    <= req_wdata[15:0];
            mem_addr   <= req_addr[9:2];
            resp_rd    <= req_rd;
            resp_store <= req_we;
            req_ready  <= 1'b0;
            if (acc_err) begin
              resp_rdata <= 32'd0;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (req_we && req_size == 2'b10) begin
              mem_wdata <= req_wdata;
              mem_we    <= 1'b1;
              state     <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: state <= DATA;
        DATA: begin
          if (we_q) begin
            mem_wdata <= merged;
            mem_we    <= 1'b1;
            state     <= WR;
          end else begin
            resp_rdata <= load_data;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WR: begin
          mem_we <= 1'b0;
          wd_cnt <= '0;
          state  <= WAIT_WD;
        end
        WAIT_WD: begin
          if (mem_wd || wd_cnt == CW'(WD_TIMEOUT - 1)) begin
            resp_rdata <= 32'd0;
            resp_err   <= ~mem_wd;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: memory model, shadow-memory response predictor,
// per-cycle compare process, and literal checks of the documented results.
module tb_mem_access_unit;

  localparam int WD_TIMEOUT = 4;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready, resp_store, resp_err;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_we, mem_wd;
  logic [2:0]  dbg_state;

  mem_access_unit #(.WD_TIMEOUT(WD_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_store(resp_store), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_wd(mem_wd), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory environment ----------------
  logic [31:0] mem [256];
  logic        wd_en;
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    mem_wd    <= mem_we & wd_en;
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        store;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [39:0] wr_q[$];
  logic [31:0] shadow [256];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] last_rdata;
  logic        last_err;
  logic [39:0] last_wr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic req_is_err(input logic [1:0] size, input logic [31:0] a);
    return (size == 2'd3) || (size == 2'd1 && a % 2 != 0) ||
           (size == 2'd2 && a % 4 != 0) || (a >= 32'd1024);
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] word, input logic [1:0] size,
                                             input logic uns, input logic [1:0] lo);
    logic [31:0] sh, field, sbit;
    sh = word >> (8 * lo);
    if (size == 2'd2) return word;
    field = (size == 2'd0) ? (sh & 32'hFF) : (sh & 32'hFFFF);
    sbit  = (size == 2'd0) ? 32'h80 : 32'h8000;
    return uns ? field : ((field ^ sbit) - sbit);
  endfunction

  function automatic logic [31:0] store_value(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] lo);
    logic [31:0] mask;
    if (size == 2'd2) return wd;
    mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * lo);
    return (old & ~mask) | ((wd << (8 * lo)) & mask);
  endfunction

  // ---------------- compare process ----------------
  logic        prev_hold, prev_valid;
  logic [38:0] prev_snap;
  always @(negedge clk) begin : compare
    exp_t e;
    int   pend;
    if (rst) begin
      exp_q.delete();
      wr_q.delete();
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      pend = exp_q.size();
      if (mem_we) begin
        if (wr_q.size() == 0) check("unexpected_we", mem_we, 1'b0);
        else begin
          check("mem_write", {mem_addr, mem_wdata}, wr_q[0]);
          last_wr = {mem_addr, mem_wdata};
          void'(wr_q.pop_front());
        end
      end
      if (prev_hold)
        check("resp_hold", {resp_valid, resp_rdata, resp_rd, resp_store, resp_err},
              {1'b1, prev_snap});
      if (resp_valid) begin
        if (exp_q.size() == 0) check("unexpected_resp", resp_valid, 1'b0);
        else begin
          e = exp_q[0];
          if (!prev_valid) check("latency", cyc - e.acc, e.lat - 1);
          if (resp_ready) begin
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_rd", resp_rd, e.rd);
            check("resp_store", resp_store, e.store);
            check("resp_err", resp_err, e.err);
            last_rdata = resp_rdata;
            last_err   = resp_err;
            void'(exp_q.pop_front());
          end
        end
      end
      prev_hold  = resp_valid && !resp_ready;
      prev_valid = resp_valid;
      prev_snap  = {resp_rdata, resp_rd, resp_store, resp_err};
      if (req_valid && req_ready) begin
        check("accept_while_busy", pend, 0);
        e.rd    = req_rd;
        e.store = req_we;
        e.acc   = cyc + 1;
        e.rdata = 32'd0;
        if (req_is_err(req_size, req_addr)) begin
          e.err = 1'b1;
          e.lat = 1;
        end else if (!req_we) begin
          e.err   = 1'b0;
          e.lat   = 3;
          e.rdata = load_value(shadow[req_addr[9:2]], req_size, req_unsigned, req_addr[1:0]);
        end else begin
          shadow[req_addr[9:2]] = store_value(shadow[req_addr[9:2]], req_wdata, req_size,
                                              req_addr[1:0]);
          wr_q.push_back({req_addr[9:2], shadow[req_addr[9:2]]});
          e.err = ~wd_en;
          e.lat = ((req_size == 2'd2) ? 3 : 5) + (wd_en ? 0 : WD_TIMEOUT - 1);
        end
        exp_q.push_back(e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic accept_wait();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_timeout", n < 50, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic issue_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    req_valid = 1'b1;
    accept_wait();
  endtask

  task automatic wait_resp();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("resp_timeout", n < 60, 1'b1);
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd);
    issue_req(we, size, uns, addr, wdata, rd);
    wait_resp();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'd0;
      shadow[i] = 32'd0;
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0; resp_ready = 1'b1; wd_en = 1'b1;
    last_rdata = 32'd0; last_err = 1'b0; last_wr = 40'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_fields", {resp_rdata, resp_rd, resp_store, resp_err}, 39'd0);
    check("rst_mem_outputs", {mem_addr, mem_wdata, mem_we}, 41'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // word store / load
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 5'd1);
    check("sw_write_lit", last_wr, 40'h04_DEADBEEF);
    check("sw_err_lit", last_err, 1'b0);
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd2);
    check("lw_lit", last_rdata, 32'hDEADBEEF);

    // byte store / loads
    run_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFFA5, 5'd3);
    check("sb_write_lit", last_wr, 40'h04_DEADA5EF);
    run_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 5'd4);
    check("lb_lit", last_rdata, 32'hFFFFFFA5);
    run_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 5'd5);
    check("lbu_lit", last_rdata, 32'h000000A5);

    // half store / loads
    run_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h00008234, 5'd6);
    check("sh_write_lit", last_wr, 40'h04_8234A5EF);
    run_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 5'd7);
    check("lh_lit", last_rdata, 32'hFFFF8234);
    run_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 5'd8);
    check("lhu_lit", last_rdata, 32'h00008234);

    // error requests: no memory write, 1-cycle latency (checked by the compare process)
    run_req(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 5'd9);
    check("err_lw_mis_lit", {last_err, last_rdata}, {1'b1, 32'd0});
    run_req(1'b1, 2'd1, 1'b0, 32'h11, 32'h1234, 5'd10);
    check("err_sh_mis_lit", last_err, 1'b1);
    run_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 5'd11);
    check("err_size_lit", last_err, 1'b1);
    run_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 5'd12);
    check("err_range_lit", last_err, 1'b1);

    // back-pressure on the response
    resp_ready = 1'b0;
    issue_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd13);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_resp_seen", resp_valid, 1'b1);
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h14; req_wdata = 32'h0; req_rd = 5'd14;
    req_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_req_ready_low", req_ready, 1'b0);
      check("bp_resp_valid", resp_valid, 1'b1);
    end
    check("bp_rdata_lit", {resp_rd, resp_rdata}, {5'd13, 32'h8234A5EF});
    resp_ready = 1'b1;
    accept_wait();
    wait_resp();
    check("bp_second_lit", last_rdata, 32'h0);

    // write-done timeout
    wd_en = 1'b0;
    run_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678, 5'd15);
    check("wd_timeout_err_lit", {last_err, last_rdata}, {1'b1, 32'd0});
    wd_en = 1'b1;

    // reset in the middle of a load
    issue_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5'd16);
    check("busy_before_rst", req_ready, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_mem_we", mem_we, 1'b0);
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    check("midrst_held_ready", req_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", req_ready, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("no_resp_after_rst", resp_valid, 1'b0);

    // one more access after reset to confirm normal operation
    run_req(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 5'd17);
    check("post_rst_lbu_lit", last_rdata, 32'h00000012);

    check("exp_q_drained", exp_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
